// File: rtl/usb_tx_if.sv
// ---------------------------------------------------------------------------
// usb_tx_if
//   Bundles the request, transmit-FIFO and bus-driver signals of the USB
//   full-speed packet transmitter.
//
//   Signals
//     tx_start       request pulse, honoured only while the transmitter idles
//     tx_pid         4-bit PID, latched with an accepted request
//     tx_byte_count  data bytes in the packet (0..64)
//     tx_data        FIFO head byte
//     fifo_empty     FIFO has no valid head
//     fifo_pop       one-cycle pulse consuming tx_data
//     tx_busy        packet in progress
//     tx_done        one-cycle pulse when the packet has ended
//     tx_error       sticky FIFO-underrun flag
//     dplus_out      D+ drive
//     dminus_out     D- drive
//
//   Modports
//     master  requester / FIFO / line monitor side
//     slave   transmitter side (usb_tx_ctrl)
// ---------------------------------------------------------------------------
interface usb_tx_if;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic [6:0] tx_byte_count;
  logic [7:0] tx_data;
  logic       fifo_empty;
  logic       fifo_pop;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       dplus_out;
  logic       dminus_out;

  modport master (
    output tx_start, tx_pid, tx_byte_count, tx_data, fifo_empty,
    input  fifo_pop, tx_busy, tx_done, tx_error, dplus_out, dminus_out
  );

  modport slave (
    input  tx_start, tx_pid, tx_byte_count, tx_data, fifo_empty,
    output fifo_pop, tx_busy, tx_done, tx_error, dplus_out, dminus_out
  );
endinterface

// File: rtl/usb_tx_ctrl.sv
// ---------------------------------------------------------------------------
// usb_tx_ctrl
//   USB full-speed packet transmitter. One packet per request:
//   SYNC (0x80), PID ({~pid, pid}), N data bytes popped from the transmit
//   FIFO, optional CRC16, then EOP (two SE0 bit times, one J bit time).
//   Bits go out LSB first, bit-stuffed after six consecutive ones and NRZI
//   encoded (0 toggles the line, 1 holds it). All outputs are registered.
//
//   Parameters
//     CLKS_PER_BIT   clock cycles per bus bit time (>= 4)
//
//   Ports
//     clk            system clock
//     n_rst          asynchronous active-low reset
//     bus            usb_tx_if.slave (request, FIFO and line signals)
//
//   Build option
//     USB_TX_CRC16_EN  when defined, a CRC16 field over the data bytes
//                      (x^16+x^15+x^2+1, init 0xFFFF, complemented, bit 15
//                      first) follows DATA.
// ---------------------------------------------------------------------------
module usb_tx_ctrl #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic      clk,
  input  logic      n_rst,
  usb_tx_if.slave   bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef USB_TX_CRC16_EN
  localparam int IW = 4;  // bit index must reach 15 inside the CRC field
`else
  localparam int IW = 3;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
`ifdef USB_TX_CRC16_EN
    ST_CRC,
`endif
    ST_EOP_SE0,
    ST_EOP_J
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;      // clock within the current bit time
  logic [IW-1:0]   idx_q, idx_d;      // index of the last real bit sent in the field
  logic [7:0]      data_q, data_d;    // SYNC / PID / data byte being sent
  logic [3:0]      pid_q, pid_d;
  logic [6:0]      left_q, left_d;    // data bytes still to load
  logic [2:0]      ones_q, ones_d;    // consecutive logical ones sent
  logic            level_q, level_d;  // NRZI level, 1 = J
  logic            dp_q, dp_d;
  logic            dm_q, dm_d;
  logic            pop_q, pop_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
`ifdef USB_TX_CRC16_EN
  logic [15:0]     crc_q, crc_d;
  logic            crc_upd;

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return fb ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
  endfunction
`endif

  logic            bit_end;
  logic            stuff_field;
  logic            send;
  logic            bit_val;
  logic            to_eop;
  logic [IW-1:0]   nxt_idx;
  logic [IW-1:0]   last_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      pid_q   <= '0;
      left_q  <= '0;
      ones_q  <= '0;
      level_q <= 1'b1;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      pop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_q   <= 16'hFFFF;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      pid_q   <= pid_d;
      left_q  <= left_d;
      ones_q  <= ones_d;
      level_q <= level_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      pop_q   <= pop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef USB_TX_CRC16_EN
      crc_q   <= crc_d;
`endif
    end
  end

  // NOTE: every variable gets a default before any branch, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    data_d  = data_q;
    pid_d   = pid_q;
    left_d  = left_q;
    ones_d  = ones_q;
    level_d = level_q;
    dp_d    = dp_q;
    dm_d    = dm_q;
    pop_d   = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    send    = 1'b0;
    bit_val = 1'b0;
    to_eop  = 1'b0;
    nxt_idx = idx_q + IW'(1);
    bit_end = (cnt_q == CNT_LAST);
    stuff_field = state_q inside {ST_SYNC, ST_PID, ST_DATA};
`ifdef USB_TX_CRC16_EN
    crc_d    = crc_q;
    crc_upd  = 1'b0;
    last_idx = (state_q == ST_CRC) ? 4'd15 : 4'd7;
    if (state_q == ST_CRC) stuff_field = 1'b1;
`else
    last_idx = 3'd7;
`endif

    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (bus.tx_start) begin
        state_d = ST_SYNC;
        pid_d   = bus.tx_pid;
        left_d  = bus.tx_byte_count;
        err_d   = 1'b0;
        idx_d   = '0;
        data_d  = 8'h80;
        ones_d  = '0;
`ifdef USB_TX_CRC16_EN
        crc_d   = 16'hFFFF;
`endif
        send    = 1'b1;
        bit_val = 1'b0;  // 0x80 sent LSB first opens with a 0
      end
    end else if (bit_end) begin
      if (stuff_field && ones_q == 3'd6) begin
        // Stuffed 0: the field pointer does not move.
        send    = 1'b1;
        bit_val = 1'b0;
      end else if (stuff_field && idx_q != last_idx) begin
        idx_d   = nxt_idx;
        send    = 1'b1;
        bit_val = data_q[nxt_idx[2:0]];
`ifdef USB_TX_CRC16_EN
        if (state_q == ST_CRC) bit_val = ~crc_q[4'd15 - nxt_idx];
        crc_upd = (state_q == ST_DATA);
`endif
      end else begin
        case (state_q)
          ST_SYNC: begin
            state_d = ST_PID;
            data_d  = {~pid_q, pid_q};
            idx_d   = '0;
            send    = 1'b1;
            bit_val = pid_q[0];
          end
          ST_PID, ST_DATA: begin
            if (left_q != 7'd0) begin
              if (bus.fifo_empty) begin
                err_d  = 1'b1;
                to_eop = 1'b1;
              end else begin
                state_d = ST_DATA;
                data_d  = bus.tx_data;
                left_d  = left_q - 7'd1;
                pop_d   = 1'b1;
                idx_d   = '0;
                send    = 1'b1;
                bit_val = bus.tx_data[0];
`ifdef USB_TX_CRC16_EN
                crc_upd = 1'b1;
`endif
              end
            end else begin
`ifdef USB_TX_CRC16_EN
              state_d = ST_CRC;
              idx_d   = '0;
              send    = 1'b1;
              bit_val = ~crc_q[15];
`else
              to_eop  = 1'b1;
`endif
            end
          end
`ifdef USB_TX_CRC16_EN
          ST_CRC: to_eop = 1'b1;
`endif
          ST_EOP_SE0: begin
            if (idx_q == '0) begin
              idx_d = IW'(1);
            end else begin
              state_d = ST_EOP_J;
              level_d = 1'b1;
              dp_d    = 1'b1;
              dm_d    = 1'b0;
            end
          end
          ST_EOP_J: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    if (to_eop) begin
      state_d = ST_EOP_SE0;
      idx_d   = '0;
      ones_d  = '0;
      dp_d    = 1'b0;
      dm_d    = 1'b0;
    end

    if (send) begin
      if (!bit_val) begin
        level_d = ~level_q;
        ones_d  = '0;
      end else begin
        ones_d  = ones_q + 3'd1;
      end
      dp_d = level_d;
      dm_d = ~level_d;
    end

`ifdef USB_TX_CRC16_EN
    if (crc_upd) crc_d = crc16_step(crc_q, bit_val);
`endif

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.fifo_pop   = pop_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_done    = done_q;
  assign bus.tx_error   = err_q;
  assign bus.dplus_out  = dp_q;
  assign bus.dminus_out = dm_q;

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_usb_tx_ctrl
//   Directed bench for usb_tx_ctrl (CLKS_PER_BIT = 8). Each packet is
//   captured as one symbol per bit time (J, K, 0 = SE0) sampled mid-bit on
//   the falling clock edge and compared with hand-derived line sequences.
//   Cycle numbers n count from the accepting rising edge: cycle T+n.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_usb_tx_ctrl;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_tx_if tif();

  usb_tx_ctrl #(.CLKS_PER_BIT(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (tif)
  );

  // Transmit FIFO model: head visible combinationally, advanced by fifo_pop.
  logic [7:0] fifo_mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign tif.tx_data    = fifo_mem[rd_ptr[3:0]];
  assign tif.fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) if (tif.fifo_pop && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;

  task automatic push(input logic [7:0] b);
    fifo_mem[wr_ptr[3:0]] = b;
    wr_ptr++;
  endtask

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_s(input string tag, input string obs, input string exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  function automatic string sym(input logic dp, input logic dm);
    case ({dp, dm})
      2'b10:   return "J";
      2'b01:   return "K";
      2'b00:   return "0";
      default: return "X";
    endcase
  endfunction

  // Per-packet observations.
  string line_s;
  int    done_n, done_cnt, pop_cnt, pop1_n, pop2_n;
  logic  busy_first, err_first, busy_done, err_done;

  // Issues one request and watches the packet. mid_n: cycle of an extra
  // tx_start pulse (0 = none). stop_n: return early at that cycle (0 = none).
  task automatic run_pkt(input logic [3:0] pid, input logic [6:0] cnt,
                         input int mid_n, input int stop_n);
    line_s = ""; done_n = -1; done_cnt = 0; pop_cnt = 0; pop1_n = -1; pop2_n = -1;
    busy_first = 1'bx; err_first = 1'bx; busy_done = 1'bx; err_done = 1'bx;
    @(negedge clk);
    tif.tx_pid = pid; tif.tx_byte_count = cnt; tif.tx_start = 1'b1;
    for (int n = 1; n <= 600; n++) begin
      @(negedge clk);
      tif.tx_start = (n == mid_n);
      if (n == mid_n) begin tif.tx_pid = ~pid; tif.tx_byte_count = 7'd5; end
      if (n == 1) begin busy_first = tif.tx_busy; err_first = tif.tx_error; end
      if (done_n < 0 && n % 8 == 4) line_s = {line_s, sym(tif.dplus_out, tif.dminus_out)};
      if (tif.fifo_pop) begin
        pop_cnt++;
        if (pop_cnt == 1) pop1_n = n;
        else if (pop_cnt == 2) pop2_n = n;
      end
      if (tif.tx_done) begin
        done_cnt++;
        if (done_n < 0) begin done_n = n; busy_done = tif.tx_busy; err_done = tif.tx_error; end
      end
      if (n == stop_n) break;
      if (done_n >= 0 && n >= done_n + 8) break;
    end
  endtask

  // Hand-derived line sequences (SYNC | PID | data | EOP).
  string e_pid2, e_ff00, e_under;
  int    d_pid2;

  initial begin
    e_ff00  = {"KJKJKJKK", "KKJJKJJK", "KKKKKKJJJ", "KJKJKJKJ", "00J"};
    e_under = {"KJKJKJKK", "KKJJKJJK", "JKJKJKJK", "00J"};
`ifdef USB_TX_CRC16_EN
    e_pid2  = {"KJKJKJKK", "JJKJJKKK", "JKJKJKJKJKJKJKJK", "00J"};
    d_pid2  = 281;
`else
    e_pid2  = {"KJKJKJKK", "JJKJJKKK", "00J"};
    d_pid2  = 153;
`endif

    n_rst = 1'b1;
    tif.tx_start = 1'b0; tif.tx_pid = 4'h0; tif.tx_byte_count = 7'd0;
    #2 n_rst = 1'b0;
    #1;
    check("reset dplus",  tif.dplus_out,  1);
    check("reset dminus", tif.dminus_out, 0);
    check("reset pop",    tif.fifo_pop,   0);
    check("reset busy",   tif.tx_busy,    0);
    check("reset done",   tif.tx_done,    0);
    check("reset error",  tif.tx_error,   0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // PID 0x2, no data.
    run_pkt(4'h2, 7'd0, 0, 0);
    check_s("pid2 line", line_s, e_pid2);
    check("pid2 done cycle", done_n, d_pid2);
    check("pid2 done count", done_cnt, 1);
    check("pid2 pops", pop_cnt, 0);
    check("pid2 busy at T+1", busy_first, 1);
    check("pid2 busy at done", busy_done, 0);
    repeat (3) @(negedge clk);

    // DATA1 with 0xFF, 0x00: one stuffed bit after the sixth 1.
    push(8'hFF); push(8'h00);
    run_pkt(4'hB, 7'd2, 0, 0);
`ifdef USB_TX_CRC16_EN
    check_s("ff00 line", line_s.substr(0, 32), e_ff00.substr(0, 32));
`else
    check_s("ff00 line", line_s, e_ff00);
    check("ff00 done cycle", done_n, 289);
`endif
    check("ff00 pops", pop_cnt, 2);
    check("ff00 first pop cycle", pop1_n, 129);
    check("ff00 pop spacing", pop2_n - pop1_n, 72);
    check("ff00 error", err_done, 0);
    repeat (3) @(negedge clk);

    // Three bytes requested, one available: underrun straight into EOP.
    push(8'h00);
    run_pkt(4'hB, 7'd3, 0, 0);
    check_s("underrun line", line_s, e_under);
    check("underrun done cycle", done_n, 217);
    check("underrun pops", pop_cnt, 1);
    check("underrun error at done", err_done, 1);
    repeat (3) @(negedge clk);
    check("underrun error sticky", tif.tx_error, 1);

    // Repeat of PID 0x2 with a tx_start pulse mid-packet.
    run_pkt(4'h2, 7'd0, 50, 0);
    check("error cleared by start", err_first, 0);
    check_s("ignored start line", line_s, e_pid2);
    check("ignored start done cycle", done_n, d_pid2);
    check("ignored start done count", done_cnt, 1);
    repeat (3) @(negedge clk);

    // Reset in the middle of the first data byte.
    push(8'hFF); push(8'h00);
    run_pkt(4'hB, 7'd2, 0, 140);
    n_rst = 1'b0;
    #1;
    check("abort dplus",  tif.dplus_out,  1);
    check("abort dminus", tif.dminus_out, 0);
    check("abort busy",   tif.tx_busy,    0);
    check("abort pop",    tif.fifo_pop,   0);
    check("abort done",   tif.tx_done,    0);
    check("abort pops before reset", pop_cnt, 1);
    check("abort no done", done_cnt, 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (4) @(negedge clk);

    // Fresh packet sends the remaining 0x00; the popped 0xFF is not resent.
    run_pkt(4'hB, 7'd1, 0, 0);
`ifdef USB_TX_CRC16_EN
    check_s("after reset line", line_s.substr(0, 23), e_under.substr(0, 23));
`else
    check_s("after reset line", line_s, e_under);
    check("after reset done cycle", done_n, 217);
`endif
    check("after reset pops", pop_cnt, 1);
    check("after reset error", err_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
